// File: rtl/whandler.sv
// whandler: write path of the 64-to-32 AXI4-Lite bridge.
// Accepts one 64-bit AXI4-Lite write upstream and replays it as one or two
// 32-bit writes downstream. addr[2]=1 issues the upper dword only; addr[2]=0
// issues the lower dword at addr, then the upper dword at addr+4. The
// upstream B response is the numeric max of all downstream B responses.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   m_aw*/m_w*/m_b*                 upstream 64-bit AXI4-Lite write slave port
//   s_aw*/s_w*/s_b*                 downstream 32-bit AXI4-Lite write master port
//
// Optional feature macro: AXI4LITE_WHANDLER_STRB_SKIP_EN
//   When defined, phases whose 4-bit strobe slice is all zero are not issued;
//   a write with no relevant strobes returns OKAY without going downstream.
module whandler #(
    parameter int unsigned M_AWADDR_WIDTH = 32,
    parameter int unsigned S_AWADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [M_AWADDR_WIDTH-1:0] m_awaddr,
    input  logic                      m_awvalid,
    output logic                      m_awready,
    input  logic [63:0]               m_wdata,
    input  logic [7:0]                m_wstrb,
    input  logic                      m_wvalid,
    output logic                      m_wready,
    output logic [1:0]                m_bresp,
    output logic                      m_bvalid,
    input  logic                      m_bready,
    output logic [S_AWADDR_WIDTH-1:0] s_awaddr,
    output logic                      s_awvalid,
    input  logic                      s_awready,
    output logic [31:0]               s_wdata,
    output logic [3:0]                s_wstrb,
    output logic                      s_wvalid,
    input  logic                      s_wready,
    input  logic [1:0]                s_bresp,
    input  logic                      s_bvalid,
    output logic                      s_bready
);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_B = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                    r_state;
    logic [M_AWADDR_WIDTH-1:0] r_addr;
    logic [63:0]               r_wdata;
    logic [7:0]                r_wstrb;
    logic                      r_aw_got;
    logic                      r_w_got;
    logic                      r_more;     // upper phase still pending after the current one
    logic [1:0]                r_resp;     // merged response of completed phases

    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_cap_done;
    logic [M_AWADDR_WIDTH-1:0] w_addr;
    logic [63:0]               w_data;
    logic [7:0]                w_strb;
    logic [M_AWADDR_WIDTH-1:0] w_hi_addr;
    logic [M_AWADDR_WIDTH-1:0] w_next_addr;
    logic [1:0]                w_merged;
    logic                      w_first_hi;
    logic                      w_more;
    logic                      w_none;

    // Captured transaction as seen this cycle, including a handshake in progress
    assign w_aw_hs     = m_awvalid & m_awready;
    assign w_w_hs      = m_wvalid & m_wready;
    assign w_cap_done  = (r_aw_got | w_aw_hs) & (r_w_got | w_w_hs);
    assign w_addr      = w_aw_hs ? m_awaddr : r_addr;
    assign w_data      = w_w_hs ? m_wdata : r_wdata;
    assign w_strb      = w_w_hs ? m_wstrb : r_wstrb;
    assign w_hi_addr   = w_addr[2] ? w_addr : w_addr + M_AWADDR_WIDTH'(4);
    assign w_next_addr = r_addr + M_AWADDR_WIDTH'(4);
    assign w_merged    = (s_bresp > r_resp) ? s_bresp : r_resp;

    // Phase plan for the freshly captured write
    always_comb begin
        w_first_hi = w_addr[2];
        w_more     = ~w_addr[2];
        w_none     = 1'b0;
`ifdef AXI4LITE_WHANDLER_STRB_SKIP_EN
        if (w_addr[2]) begin
            w_none = ~|w_strb[7:4];
        end else if (~|w_strb[3:0]) begin
            w_first_hi = 1'b1;
            w_more     = 1'b0;
            w_none     = ~|w_strb[7:4];
        end else begin
            w_more = |w_strb[7:4];
        end
`endif
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ACCEPT;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_more    <= 1'b0;
            r_resp    <= 2'b00;
            m_awready <= 1'b0;
            m_wready  <= 1'b0;
            m_bvalid  <= 1'b0;
            m_bresp   <= 2'b00;
            s_awvalid <= 1'b0;
            s_wvalid  <= 1'b0;
            s_bready  <= 1'b0;
            s_awaddr  <= '0;
            s_wdata   <= '0;
            s_wstrb   <= '0;
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    if (w_aw_hs) begin
                        r_addr    <= m_awaddr;
                        r_aw_got  <= 1'b1;
                        m_awready <= 1'b0;
                    end else if (!r_aw_got) begin
                        m_awready <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= m_wdata;
                        r_wstrb  <= m_wstrb;
                        r_w_got  <= 1'b1;
                        m_wready <= 1'b0;
                    end else if (!r_w_got) begin
                        m_wready <= 1'b1;
                    end
                    if (w_cap_done) begin
                        r_more <= w_more;
                        if (w_none) begin
                            m_bvalid <= 1'b1;
                            m_bresp  <= 2'b00;
                            r_state  <= ST_RESP;
                        end else begin
                            s_awaddr  <= S_AWADDR_WIDTH'(w_first_hi ? w_hi_addr : w_addr);
                            s_wdata   <= w_first_hi ? w_data[63:32] : w_data[31:0];
                            s_wstrb   <= w_first_hi ? w_strb[7:4] : w_strb[3:0];
                            s_awvalid <= 1'b1;
                            s_wvalid  <= 1'b1;
                            r_state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (s_awvalid && s_awready) s_awvalid <= 1'b0;
                    if (s_wvalid && s_wready)   s_wvalid  <= 1'b0;
                    if ((!s_awvalid || s_awready) && (!s_wvalid || s_wready)) begin
                        s_bready <= 1'b1;
                        r_state  <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (s_bvalid) begin
                        s_bready <= 1'b0;
                        if (r_more) begin
                            // Only aligned writes have a second phase, so addr+4 is the upper dword
                            r_more    <= 1'b0;
                            r_resp    <= w_merged;
                            s_awaddr  <= S_AWADDR_WIDTH'(w_next_addr);
                            s_wdata   <= r_wdata[63:32];
                            s_wstrb   <= r_wstrb[7:4];
                            s_awvalid <= 1'b1;
                            s_wvalid  <= 1'b1;
                            r_state   <= ST_ISSUE;
                        end else begin
                            m_bvalid <= 1'b1;
                            m_bresp  <= w_merged;
                            r_state  <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (m_bready) begin
                        m_bvalid  <= 1'b0;
                        m_bresp   <= 2'b00;
                        r_resp    <= 2'b00;
                        r_aw_got  <= 1'b0;
                        r_w_got   <= 1'b0;
                        m_awready <= 1'b1;
                        m_wready  <= 1'b1;
                        r_state   <= ST_ACCEPT;
                    end
                end
                default: r_state <= ST_ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_whandler.sv
// Directed self-checking bench for whandler (32-bit address build).
module tb_whandler;

    logic        clk;
    logic        rst_n;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;

    int n_tests = 0;
    int n_fail  = 0;

    whandler #(.M_AWADDR_WIDTH(32), .S_AWADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Upstream AW+W; W is offered immediately, AW after aw_dly cycles
    task automatic master_write(input logic [31:0] a, input logic [63:0] d,
                                input logic [7:0] s, input int aw_dly);
        logic aw_done, w_done, aw_fire, w_fire;
        aw_done = 1'b0;
        w_done  = 1'b0;
        m_awaddr = a;
        m_wdata  = d;
        m_wstrb  = s;
        m_wvalid = 1'b1;
        for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
            if (c == aw_dly && !aw_done) m_awvalid = 1'b1;
            aw_fire = m_awvalid && m_awready;
            w_fire  = m_wvalid && m_wready;
            @(negedge clk);
            if (aw_fire) begin m_awvalid = 1'b0; aw_done = 1'b1; end
            if (w_fire)  begin m_wvalid  = 1'b0; w_done  = 1'b1; end
        end
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        check("m_aw_w_accepted", 64'({aw_done, w_done}), 64'(2'b11));
    endtask

    // Downstream AW/W handshake of one phase with optional ready delays
    task automatic slave_accept(input logic [31:0] ea, input logic [31:0] ed,
                                input logic [3:0] es, input int aw_dly, input int w_dly);
        int   waitc;
        logic aw_done, w_done, aw_fire, w_fire, stable;
        waitc = 0;
        while (!(s_awvalid && s_wvalid) && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("s_valid_latency", 64'(waitc), 64'(0));
        check("s_awaddr", 64'(s_awaddr), 64'(ea));
        check("s_wdata", 64'(s_wdata), 64'(ed));
        check("s_wstrb", 64'(s_wstrb), 64'(es));
        aw_done = 1'b0;
        w_done  = 1'b0;
        stable  = 1'b1;
        for (int c = 0; c < 30 && !(aw_done && w_done); c++) begin
            if (!aw_done && (s_awvalid !== 1'b1 || s_awaddr !== ea)) stable = 1'b0;
            if (!w_done && (s_wvalid !== 1'b1 || s_wdata !== ed || s_wstrb !== es)) stable = 1'b0;
            if (aw_done && s_awvalid !== 1'b0) stable = 1'b0;
            if (w_done && s_wvalid !== 1'b0) stable = 1'b0;
            s_awready = !aw_done && (c >= aw_dly);
            s_wready  = !w_done && (c >= w_dly);
            aw_fire = s_awready && s_awvalid;
            w_fire  = s_wready && s_wvalid;
            @(negedge clk);
            if (aw_fire) aw_done = 1'b1;
            if (w_fire)  w_done  = 1'b1;
        end
        s_awready = 1'b0;
        s_wready  = 1'b0;
        check("s_payload_stable", 64'(stable), 64'(1));
        check("s_valids_dropped", 64'({s_awvalid, s_wvalid}), 64'(2'b00));
        check("s_bready_up", 64'(s_bready), 64'(1));
    endtask

    // Downstream B beat for the current phase
    task automatic slave_b(input logic [1:0] rsp);
        s_bresp  = rsp;
        s_bvalid = 1'b1;
        @(negedge clk);
        s_bvalid = 1'b0;
        s_bresp  = 2'b00;
        check("s_bready_drop", 64'(s_bready), 64'(0));
    endtask

    // Upstream B: expect response now, hold m_bready off for dly cycles
    task automatic master_b(input logic [1:0] exp, input int dly);
        logic hold_ok;
        check("m_bvalid", 64'(m_bvalid), 64'(1));
        check("m_bresp", 64'(m_bresp), 64'(exp));
        hold_ok = 1'b1;
        for (int c = 0; c < dly; c++) begin
            @(negedge clk);
            if (m_bvalid !== 1'b1 || m_bresp !== exp) hold_ok = 1'b0;
        end
        check("m_b_hold", 64'(hold_ok), 64'(1));
        m_bready = 1'b1;
        @(negedge clk);
        m_bready = 1'b0;
        check("m_bvalid_drop", 64'(m_bvalid), 64'(0));
        check("m_readies_back", 64'({m_awready, m_wready}), 64'(2'b11));
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0;
        m_awaddr = '0; m_awvalid = 1'b0; m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0;
        m_bready = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctrl", 64'({m_awready, m_wready, m_bvalid, m_bresp, s_awvalid, s_wvalid, s_bready}),
              64'(0));
        check("rst_payload", 64'({s_awaddr, s_wdata}), 64'(0));
        check("rst_wstrb", 64'(s_wstrb), 64'(0));
        rst_n = 1'b1;
        #1;
        check("readies_before_edge", 64'({m_awready, m_wready}), 64'(2'b00));
        @(negedge clk);
        check("readies_after_edge", 64'({m_awready, m_wready}), 64'(2'b11));

        // Aligned write, both phases OKAY
        master_write(32'h100, 64'h1122334455667788, 8'hFF, 0);
        slave_accept(32'h100, 32'h55667788, 4'hF, 0, 0);
        slave_b(2'b00);
        slave_accept(32'h104, 32'h11223344, 4'hF, 0, 0);
        slave_b(2'b00);
        master_b(2'b00, 0);

        // Upper-dword write: single phase
        master_write(32'h10C, 64'hAABBCCDD_00000000, 8'hF0, 0);
        slave_accept(32'h10C, 32'hAABBCCDD, 4'hF, 0, 0);
        slave_b(2'b00);
        check("single_phase_no_more", 64'(s_awvalid), 64'(0));
        master_b(2'b00, 0);

        // Lower SLVERR, upper still issued, merged SLVERR
        master_write(32'h180, 64'h0123456789ABCDEF, 8'h3C, 0);
        slave_accept(32'h180, 32'h89ABCDEF, 4'hC, 0, 0);
        slave_b(2'b10);
        slave_accept(32'h184, 32'h01234567, 4'h3, 0, 0);
        slave_b(2'b00);
        master_b(2'b10, 0);

        // W three cycles before AW, slow s_wready, late m_bready
        master_write(32'h1F8, 64'h99887766_55443322, 8'hFF, 3);
        slave_accept(32'h1F8, 32'h55443322, 4'hF, 0, 2);
        slave_b(2'b00);
        slave_accept(32'h1FC, 32'h99887766, 4'hF, 0, 2);
        slave_b(2'b00);
        master_b(2'b00, 4);

        // Asynchronous reset while waiting for the lower-phase B
        master_write(32'h300, 64'hCAFEBABE_DEADBEEF, 8'hFF, 0);
        slave_accept(32'h300, 32'hDEADBEEF, 4'hF, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ctrl", 64'({m_awready, m_wready, m_bvalid, m_bresp, s_awvalid, s_wvalid, s_bready}),
              64'(0));
        check("async_rst_payload", 64'({s_awaddr, s_wdata}), 64'(0));
        check("async_rst_wstrb", 64'(s_wstrb), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (m_bvalid !== 1'b0 || s_awvalid !== 1'b0) seen = 1'b1;
        end
        check("no_b_after_rst", 64'(seen), 64'(0));

        // Normal write after reset; upper DECERR dominates
        master_write(32'h400, 64'h0000FFFF_12345678, 8'hFF, 0);
        slave_accept(32'h400, 32'h12345678, 4'hF, 0, 0);
        slave_b(2'b00);
        slave_accept(32'h404, 32'h0000FFFF, 4'hF, 0, 0);
        slave_b(2'b11);
        master_b(2'b11, 0);

`ifdef AXI4LITE_WHANDLER_STRB_SKIP_EN
        // Lower strobes zero: only the upper phase goes out
        master_write(32'h200, 64'h13579BDF_2468ACE0, 8'hF0, 0);
        slave_accept(32'h204, 32'h13579BDF, 4'hF, 0, 0);
        slave_b(2'b00);
        check("skip_single_phase", 64'(s_awvalid), 64'(0));
        master_b(2'b00, 0);

        // No strobes: OKAY without any downstream transaction
        master_write(32'h200, 64'h13579BDF_2468ACE0, 8'h00, 0);
        check("skip_all_no_aw", 64'(s_awvalid), 64'(0));
        master_b(2'b00, 0);
`else
        // Strobes do not suppress phases
        master_write(32'h200, 64'h13579BDF_2468ACE0, 8'hF0, 0);
        slave_accept(32'h200, 32'h2468ACE0, 4'h0, 0, 0);
        slave_b(2'b00);
        slave_accept(32'h204, 32'h13579BDF, 4'hF, 0, 0);
        slave_b(2'b00);
        master_b(2'b00, 0);

        master_write(32'h200, 64'h13579BDF_2468ACE0, 8'h00, 0);
        slave_accept(32'h200, 32'h2468ACE0, 4'h0, 0, 0);
        slave_b(2'b00);
        slave_accept(32'h204, 32'h13579BDF, 4'h0, 0, 0);
        slave_b(2'b00);
        master_b(2'b00, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
